// File: rtl/video_timing_pkg.sv
// Mode table and helpers shared by the video timing generator and its axis counters.
// Each entry describes one display mode; totals are derived, never stored.
package video_timing_pkg;

    localparam int VT_MAX_MODES = 8;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_res;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } vt_mode_t;

    localparam vt_mode_t MODE_640X480 = '{
        h_res: 16'd640,  h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_res: 16'd480,  v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0};
    localparam vt_mode_t MODE_800X600 = '{
        h_res: 16'd800,  h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_res: 16'd600,  v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        h_pol: 1'b1, v_pol: 1'b1};
    localparam vt_mode_t MODE_768X576 = '{
        h_res: 16'd768,  h_fp: 16'd32, h_sync: 16'd80,  h_bp: 16'd112,
        v_res: 16'd576,  v_fp: 16'd1,  v_sync: 16'd3,   v_bp: 16'd21,
        h_pol: 1'b0, v_pol: 1'b1};
    localparam vt_mode_t MODE_1024X768 = '{
        h_res: 16'd1024, h_fp: 16'd24, h_sync: 16'd136, h_bp: 16'd160,
        v_res: 16'd768,  v_fp: 16'd3,  v_sync: 16'd6,   v_bp: 16'd29,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam vt_mode_t MODE_TABLE [VT_MAX_MODES] = '{
        MODE_640X480, MODE_800X600, MODE_768X576, MODE_1024X768,
        MODE_640X480, MODE_640X480, MODE_640X480, MODE_640X480};

    function automatic logic sync_idle(input logic pol);
        return ~pol;
    endfunction

    function automatic logic sync_drive(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

    function automatic int unsigned h_total(input vt_mode_t m);
        return 32'(m.h_res) + 32'(m.h_fp) + 32'(m.h_sync) + 32'(m.h_bp);
    endfunction

    function automatic int unsigned v_total(input vt_mode_t m);
        return 32'(m.v_res) + 32'(m.v_fp) + 32'(m.v_sync) + 32'(m.v_bp);
    endfunction

    function automatic int unsigned h_sync_beg(input vt_mode_t m);
        return 32'(m.h_res) + 32'(m.h_fp);
    endfunction

    function automatic int unsigned h_sync_end(input vt_mode_t m);
        return 32'(m.h_res) + 32'(m.h_fp) + 32'(m.h_sync);
    endfunction

    function automatic int unsigned v_sync_beg(input vt_mode_t m);
        return 32'(m.v_res) + 32'(m.v_fp);
    endfunction

    function automatic int unsigned v_sync_end(input vt_mode_t m);
        return 32'(m.v_res) + 32'(m.v_fp) + 32'(m.v_sync);
    endfunction

endpackage

// File: rtl/vt_axis_counter.sv
// One timing axis: position counter, wrap detect and registered sync decode.
// Wrap uses the limits of the mode in force; decode uses the mode of the next pixel.
module vt_axis_counter
    import video_timing_pkg::*;
#(
    parameter int   COORD_W = 13,
    parameter logic RST_POL = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               step,
    input  logic               start,
    input  logic [COORD_W-1:0] total,
    input  logic [COORD_W-1:0] res,
    input  logic [COORD_W-1:0] sync_beg,
    input  logic [COORD_W-1:0] sync_end,
    input  logic               pol,
    output logic [COORD_W-1:0] cnt,
    output logic [COORD_W-1:0] nxt_cnt,
    output logic               wrap,
    output logic               nxt_active,
    output logic               sync
);

    assign wrap = (cnt == total - 1'b1);

    // start parks the counter at 0 so the first pixel after reset is (0,0)
    always_comb begin
        nxt_cnt = cnt;
        if (start)
            nxt_cnt = '0;
        else if (step)
            nxt_cnt = wrap ? '0 : cnt + 1'b1;
    end

    assign nxt_active = (nxt_cnt < res);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            sync <= sync_idle(RST_POL);
        end else begin
            cnt  <= nxt_cnt;
            sync <= sync_drive((nxt_cnt >= sync_beg) && (nxt_cnt < sync_end), pol);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode display timing generator with frame-boundary mode switching.
// Define VIDEO_TIMING_LOOKAHEAD_EN to add registered next-pixel outputs (o_next_x/y/de).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int N_MODES      = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int COORD_W      = 13
) (
    input  logic               i_pixel_clk,
    input  logic               i_resetn,
    input  logic [2:0]         i_mode_sel,
    input  logic               i_mode_req,
    output logic [2:0]         o_hve,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [2:0]         o_mode_active,
    output logic               o_mode_err
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
    ,
    output logic [COORD_W-1:0] o_next_x,
    output logic [COORD_W-1:0] o_next_y,
    output logic               o_next_de
`endif
);

    localparam logic [2:0] DEF_M = 3'(DEFAULT_MODE);

    if (N_MODES < 1 || N_MODES > VT_MAX_MODES) begin : g_bad_n
        $error("video_timing_gen: N_MODES out of range");
    end
    if (DEFAULT_MODE < 0 || DEFAULT_MODE >= N_MODES) begin : g_bad_def
        $error("video_timing_gen: DEFAULT_MODE out of range");
    end
    for (genvar i = 0; i < N_MODES; i++) begin : g_chk
        if ((h_total(MODE_TABLE[i]) >> COORD_W) != 0 ||
            (v_total(MODE_TABLE[i]) >> COORD_W) != 0) begin : g_bad_total
            $error("video_timing_gen: mode total does not fit COORD_W");
        end
    end

    logic               run;
    logic [2:0]         mode, mode_n, pend_mode, pend_mode_n;
    logic               pend, pend_n, sel_ok, acc_req, sw;
    logic               de_q, ls_q, fs_q, err_q;

    logic [COORD_W-1:0] h_tot, v_tot;
    logic [COORD_W-1:0] h_res_n, h_sb_n, h_se_n, v_res_n, v_sb_n, v_se_n;
    logic               h_pol_n, v_pol_n;

    logic [COORD_W-1:0] x, y, x_n, y_n;
    logic               x_wrap, y_wrap, h_act_n, v_act_n, hs, vs;

    assign sel_ok  = ({1'b0, i_mode_sel} < 4'(N_MODES));
    assign acc_req = i_mode_req && sel_ok;
    assign sw      = run && x_wrap && y_wrap && pend;

    assign mode_n      = sw ? pend_mode : mode;
    assign pend_n      = acc_req ? 1'b1 : (sw ? 1'b0 : pend);
    assign pend_mode_n = acc_req ? i_mode_sel : pend_mode;

    // wrap is judged against the running mode, decode against the mode of the next pixel
    assign h_tot   = COORD_W'(h_total(MODE_TABLE[mode]));
    assign v_tot   = COORD_W'(v_total(MODE_TABLE[mode]));
    assign h_res_n = COORD_W'(MODE_TABLE[mode_n].h_res);
    assign v_res_n = COORD_W'(MODE_TABLE[mode_n].v_res);
    assign h_sb_n  = COORD_W'(h_sync_beg(MODE_TABLE[mode_n]));
    assign h_se_n  = COORD_W'(h_sync_end(MODE_TABLE[mode_n]));
    assign v_sb_n  = COORD_W'(v_sync_beg(MODE_TABLE[mode_n]));
    assign v_se_n  = COORD_W'(v_sync_end(MODE_TABLE[mode_n]));
    assign h_pol_n = MODE_TABLE[mode_n].h_pol;
    assign v_pol_n = MODE_TABLE[mode_n].v_pol;

    vt_axis_counter #(
        .COORD_W (COORD_W),
        .RST_POL (MODE_TABLE[DEFAULT_MODE].h_pol)
    ) u_h (
        .clk        (i_pixel_clk),
        .resetn     (i_resetn),
        .step       (1'b1),
        .start      (!run),
        .total      (h_tot),
        .res        (h_res_n),
        .sync_beg   (h_sb_n),
        .sync_end   (h_se_n),
        .pol        (h_pol_n),
        .cnt        (x),
        .nxt_cnt    (x_n),
        .wrap       (x_wrap),
        .nxt_active (h_act_n),
        .sync       (hs)
    );

    vt_axis_counter #(
        .COORD_W (COORD_W),
        .RST_POL (MODE_TABLE[DEFAULT_MODE].v_pol)
    ) u_v (
        .clk        (i_pixel_clk),
        .resetn     (i_resetn),
        .step       (x_wrap),
        .start      (!run),
        .total      (v_tot),
        .res        (v_res_n),
        .sync_beg   (v_sb_n),
        .sync_end   (v_se_n),
        .pol        (v_pol_n),
        .cnt        (y),
        .nxt_cnt    (y_n),
        .wrap       (y_wrap),
        .nxt_active (v_act_n),
        .sync       (vs)
    );

    always_ff @(posedge i_pixel_clk) begin
        if (!i_resetn) begin
            run       <= 1'b0;
            mode      <= DEF_M;
            pend      <= 1'b0;
            pend_mode <= DEF_M;
            de_q      <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            run       <= 1'b1;
            mode      <= mode_n;
            pend      <= pend_n;
            pend_mode <= pend_mode_n;
            de_q      <= h_act_n && v_act_n;
            ls_q      <= (x_n == '0);
            fs_q      <= (x_n == '0) && (y_n == '0);
            err_q     <= i_mode_req && !sel_ok;
        end
    end

    assign o_hve         = {de_q, vs, hs};
    assign o_x           = x;
    assign o_y           = y;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
    assign o_mode_active = mode;
    assign o_mode_err    = err_q;

`ifdef VIDEO_TIMING_LOOKAHEAD_EN
    // Second step of the same recurrence, taken from the pixel about to be loaded
    logic [COORD_W-1:0] h_last2, v_last2, nn_x, nn_y;
    logic               w2x, w2y, sw2;
    logic [2:0]         mode2;

    assign h_last2 = COORD_W'(h_total(MODE_TABLE[mode_n])) - 1'b1;
    assign v_last2 = COORD_W'(v_total(MODE_TABLE[mode_n])) - 1'b1;
    assign w2x     = (x_n == h_last2);
    assign w2y     = (y_n == v_last2);
    assign sw2     = w2x && w2y && pend_n;
    assign mode2   = sw2 ? pend_mode_n : mode_n;
    assign nn_x    = w2x ? '0 : x_n + 1'b1;
    assign nn_y    = w2x ? (w2y ? '0 : y_n + 1'b1) : y_n;

    always_ff @(posedge i_pixel_clk) begin
        if (!i_resetn) begin
            o_next_x  <= '0;
            o_next_y  <= '0;
            o_next_de <= 1'b0;
        end else begin
            o_next_x  <= nn_x;
            o_next_y  <= nn_y;
            o_next_de <= (nn_x < COORD_W'(MODE_TABLE[mode2].h_res)) &&
                         (nn_y < COORD_W'(MODE_TABLE[mode2].v_res));
        end
    end
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Multi-mode display timing generator; successor to the fixed-parameter display_signal generator.
- Drives the pixel-clock domain ahead of the hdmi encoder and supplies `o_hve`, `o_x` and `o_y` with the same meaning as before.
- Adds a runtime-selectable mode table, glitch-free mode switching at frame boundaries, line/frame strobes and a synchronous active-low reset.

Parameters:
- N_MODES, 4, number of mode-table entries used (1..8).
- DEFAULT_MODE, 0, mode index loaded at reset.
- COORD_W, 13, width of the x/y counters and coordinate outputs.

Ports:
- i_pixel_clk  in  1  pixel clock; the only clock.
- i_resetn  in  1  synchronous, active-low reset.
- i_mode_sel  in  3  requested mode index.
- i_mode_req  in  1  single-cycle strobe that captures `i_mode_sel`.
- o_hve  out  3  {de, vsync, hsync}: bit2 = data enable, bit1 = vsync, bit0 = hsync, polarity already applied.
- o_x  out  COORD_W  horizontal position counter.
- o_y  out  COORD_W  vertical position counter.
- o_line_start  out  1  high when o_x == 0.
- o_frame_start  out  1  high when o_x == 0 and o_y == 0.
- o_mode_active  out  3  mode index currently being generated.
- o_mode_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Each mode entry holds h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp, h_pol and v_pol.
  - h_total = h_res + h_fp + h_sync + h_bp; v_total is formed the same way.
- Counter order per line: active [0, h_res), front porch, sync, back porch. The vertical axis uses the same order.
- hsync is asserted when x is in [h_res+h_fp, h_res+h_fp+h_sync); vsync uses the same rule on y.
  - pol = 1: asserted sync is driven 1.
  - pol = 0: asserted sync is driven 0.
- de = (x < h_res) && (y < v_res).
- All outputs are registered. `o_hve`, `o_line_start` and `o_frame_start` describe the same pixel as `o_x`/`o_y` in the same cycle.
- Counting:
  - x increments every cycle.
  - At x == h_total-1: x wraps to 0 and y increments.
  - At y == v_total-1 with the x wrap: y wraps to 0.
- Reset (i_resetn = 0 at an edge):
  - x = 0, y = 0; mode_active = DEFAULT_MODE; pending request cleared.
  - o_hve = {0, inactive vsync, inactive hsync} for DEFAULT_MODE.
  - o_line_start = 0, o_frame_start = 0, o_mode_err = 0.
- First cycle after reset release: x = 0, y = 0, de = 1, o_line_start = 1, o_frame_start = 1.
- Reset asserted mid-frame aborts the frame immediately. No partial line completes.
- Mode request handling:
  - i_mode_req with i_mode_sel < N_MODES: latched into a pending register with the pending flag set.
  - A newer request overwrites the pending one.
  - i_mode_sel >= N_MODES: request ignored, pending state unchanged, o_mode_err = 1 on the next cycle.
- Switch point:
  - At the frame-wrap edge (x = h_total-1, y = v_total-1) with the pending flag set, the next cycle starts at (0,0) using the new mode. o_mode_active updates in that same cycle and the pending flag clears.
  - A request arriving on the wrap cycle itself is not applied at that boundary; it waits for the next one.
- Requesting the mode already active is legal and treated as a normal request (no timing disturbance).
- Counters never exceed total-1 for the active mode. Mode tables with any total >= 2^COORD_W are illegal; an elaboration-time assertion enforces this.

Optional Feature:
- Macro: VIDEO_TIMING_LOOKAHEAD_EN.
- When defined, the block adds o_next_x / o_next_y (COORD_W) and o_next_de (1).
  - These are registered and equal the values that o_x / o_y / de will take in the next cycle.
  - Across a mode switch they follow the new mode.
  - Reset values are 0 / 0 / 0. After reset release, o_next_* first equal (1, 0, 1).
  - Purpose: one-cycle-latency pixel fetch.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package video_timing_pkg holds:
  - typedef struct vt_mode_t with the ten mode fields;
  - constant MODE_TABLE[8];
  - inactive-level helper functions;
  - constant VT_MAX_MODES = 8.
- MODE_TABLE entries:
  - entry 0: 640x480@60 (16/96/48, 10/2/33, pol 0/0);
  - entry 1: 800x600@60 (40/128/88, 1/4/23, pol 1/1);
  - entry 2: 768x576@73 (32/80/112, 1/3/21, pol 0/1);
  - entry 3: 1024x768@60 (24/136/160, 3/6/29, pol 0/0);
  - entries 4-7: copies of entry 0.
- One sub-module, vt_axis_counter, instantiated twice (horizontal and vertical). It contains the counter, wrap detection and sync/active decode for one axis, with a step-enable input and a runtime limits input.

Test Plan:
- Reset, mode 0, run 2 frames:
  - frame length 420000 cycles (800x525);
  - hsync = 0 exactly for x 656..751;
  - vsync = 0 for y 490..491;
  - de count per frame = 307200.
- Pulse i_mode_req with sel = 3 at (x=100, y=10):
  - o_mode_active stays 0 until the frame wrap;
  - the next frame is 1344x806;
  - o_frame_start is high in the cycle of the switch.
- Pulse i_mode_req with sel = 5 while N_MODES = 4:
  - o_mode_err high for 1 cycle;
  - timing stays on the current mode.
- Two requests (sel = 1, then sel = 2) within one frame:
  - only mode 2 is applied at the wrap;
  - mode 1 is never generated.
- Request on the exact wrap cycle (x=799, y=524 in mode 0):
  - the switch occurs one frame later, after 420000 further cycles.
- i_resetn low at (x=500, y=300) in mode 3 for 2 cycles:
  - outputs are at reset values during reset;
  - after release: (0,0), o_mode_active = DEFAULT_MODE, pending request discarded.
